// File: rtl/sar_pkg.sv
// Shared encodings for the successive-approximation search controller.
package sar_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    QUERY = 1'b1
  } sarState_e;

  // Packed as {iLarge, iSmall}
  typedef enum logic [1:0] {
    EQ  = 2'b00,
    LT  = 2'b01,
    GT  = 2'b10,
    ERR = 2'b11
  } verdict_e;

  // The step counter must be able to hold WIDTH+1.
  function automatic int sarStepW(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/sar_search.sv
// Binary search of a hidden target through a greater/less/equal comparator.
//   state | meaning
//   IDLE  | no search running; waits for iStart, ignores verdicts
//   QUERY | oGuess presented, waiting for a verdict to narrow [lo, hi]
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEPW = sarStepW(WIDTH)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  output logic [WIDTH-1:0] oGuess,
  output logic             oGuessValid,
  input  logic             iRespValid,
  input  logic             iLarge,
  input  logic             iSmall,
  output logic [WIDTH-1:0] oResult,
  output logic [STEPW-1:0] oSteps,
  output logic             oBusy,
  output logic             oDone,
  output logic             oError
);

  localparam int BW = WIDTH + 1;

  sarState_e        stateQ, stateD;
  logic [BW-1:0]    loQ, loD, hiQ, hiD;
  logic [WIDTH-1:0] guessQ, guessD, resultQ, resultD;
  logic [STEPW-1:0] stepsQ, stepsD;
  logic             doneQ, doneD, errorQ, errorD;

  verdict_e         verdict;
  logic [BW-1:0]    guessExt, loNew, hiNew, midSum;

  assign verdict  = verdict_e'({iLarge, iSmall});
  assign guessExt = {1'b0, guessQ};

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateQ  <= IDLE;
      loQ     <= '0;
      hiQ     <= '0;
      guessQ  <= '0;
      resultQ <= '0;
      stepsQ  <= '0;
      doneQ   <= 1'b0;
      errorQ  <= 1'b0;
    end else begin
      stateQ  <= stateD;
      loQ     <= loD;
      hiQ     <= hiD;
      guessQ  <= guessD;
      resultQ <= resultD;
      stepsQ  <= stepsD;
      doneQ   <= doneD;
      errorQ  <= errorD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    loD     = loQ;
    hiD     = hiQ;
    guessD  = guessQ;
    resultD = resultQ;
    stepsD  = stepsQ;
    doneD   = 1'b0;
    errorD  = 1'b0;
    loNew   = loQ;
    hiNew   = hiQ;
    midSum  = '0;

    case (stateQ)
      IDLE: begin
        if (iStart) begin
          loD    = '0;
          hiD    = {1'b0, {WIDTH{1'b1}}};
          midSum = {1'b0, {WIDTH{1'b1}}};
          guessD = midSum[BW-1:1];
          stepsD = '0;
          stateD = QUERY;
        end
      end
      QUERY: begin
        if (iRespValid) begin
          stepsD = stepsQ + STEPW'(1);
          case (verdict)
            EQ: begin
              resultD = guessQ;
              doneD   = 1'b1;
              stateD  = IDLE;
            end
            GT:      hiNew = guessExt - BW'(1);
            LT:      loNew = guessExt + BW'(1);
            default: begin
              errorD = 1'b1;
              stateD = IDLE;
            end
          endcase
          // hi below zero shows as its top bit set; lo above max shows as lo > hi
          if (verdict == GT || verdict == LT) begin
            if (hiNew[WIDTH] || (loNew > hiNew)) begin
              errorD = 1'b1;
              stateD = IDLE;
            end else begin
              loD    = loNew;
              hiD    = hiNew;
              midSum = loNew + hiNew;
              guessD = midSum[BW-1:1];
            end
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  assign oGuess      = guessQ;
  assign oGuessValid = (stateQ == QUERY);
  assign oBusy       = (stateQ == QUERY);
  assign oResult     = resultQ;
  assign oSteps      = stepsQ;
  assign oDone       = doneQ;
  assign oError      = errorQ;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search with a behavioural comparator responder.
module tb_sar_search;

  localparam int WIDTH = 4;
  localparam int STEPW = 3;

  logic             iClk = 1'b0;
  logic             iRst = 1'b1;
  logic             iStart = 1'b0;
  logic [WIDTH-1:0] oGuess;
  logic             oGuessValid;
  logic             iRespValid = 1'b0;
  logic             iLarge = 1'b0;
  logic             iSmall = 1'b0;
  logic [WIDTH-1:0] oResult;
  logic [STEPW-1:0] oSteps;
  logic             oBusy;
  logic             oDone;
  logic             oError;

  sar_search #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iStart      (iStart),
    .oGuess      (oGuess),
    .oGuessValid (oGuessValid),
    .iRespValid  (iRespValid),
    .iLarge      (iLarge),
    .iSmall      (iSmall),
    .oResult     (oResult),
    .oSteps      (oSteps),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oError      (oError)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int failures = 0;
  int gq[$];
  int expQ[$];
  bit gotDone;
  bit gotError;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkSeq(input string tag, input int exp[$]);
    chk({tag, "_len"}, gq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < gq.size(); i++)
      chk($sformatf("%s_g%0d", tag, i), gq[i], exp[i]);
  endtask

  // mode 0: honest comparator, 1: always Large, 2: both flags on first verdict
  task automatic runSearch(input int target, input int maxDelay, input int mode,
                           input bit midStart);
    int d;
    gq.delete();
    gotDone  = 1'b0;
    gotError = 1'b0;
    @(negedge iClk) iStart = 1'b1;
    @(negedge iClk) iStart = 1'b0;
    for (int a = 0; a < 8 && !gotDone && !gotError; a++) begin
      if (midStart && a == 1) begin
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
      end
      d = (maxDelay > 0) ? int'($urandom_range(0, maxDelay)) : 0;
      repeat (d) @(negedge iClk);
      chk("guess_valid", {31'b0, oGuessValid}, 1);
      gq.push_back(int'(oGuess));
      iRespValid = 1'b1;
      case (mode)
        1: begin iLarge = 1'b1; iSmall = 1'b0; end
        2: begin iLarge = 1'b1; iSmall = 1'b1; end
        default: begin
          iLarge = (int'(oGuess) > target);
          iSmall = (int'(oGuess) < target);
        end
      endcase
      @(negedge iClk);
      iRespValid = 1'b0;
      iLarge     = 1'b0;
      iSmall     = 1'b0;
      gotDone    = oDone;
      gotError   = oError;
    end
    chk("terminated", {31'b0, gotDone | gotError}, 1);
  endtask

  initial begin
    repeat (2) @(negedge iClk);
    chk("rst_busy", {31'b0, oBusy}, 0);
    chk("rst_valid", {31'b0, oGuessValid}, 0);
    chk("rst_guess", {28'b0, oGuess}, 0);
    chk("rst_result", {28'b0, oResult}, 0);
    chk("rst_steps", {29'b0, oSteps}, 0);
    chk("rst_done", {31'b0, oDone}, 0);
    chk("rst_error", {31'b0, oError}, 0);
    iRst = 1'b0;

    // verdicts in IDLE are ignored
    @(negedge iClk) begin iRespValid = 1'b1; iSmall = 1'b1; end
    @(negedge iClk) begin iRespValid = 1'b0; iSmall = 1'b0; end
    chk("idle_resp_busy", {31'b0, oBusy}, 0);
    chk("idle_resp_steps", {29'b0, oSteps}, 0);
    chk("idle_resp_err", {31'b0, oError}, 0);

    // first guess valid the cycle after iStart
    @(negedge iClk) iStart = 1'b1;
    @(negedge iClk) iStart = 1'b0;
    chk("first_valid", {31'b0, oGuessValid}, 1);
    chk("first_busy", {31'b0, oBusy}, 1);
    chk("first_guess", {28'b0, oGuess}, 7);
    @(negedge iClk) begin iRespValid = 1'b1; end
    @(negedge iClk) begin iRespValid = 1'b0; end
    chk("first_eq_done", {31'b0, oDone}, 1);
    chk("first_eq_result", {28'b0, oResult}, 7);
    @(negedge iClk);
    chk("done_one_cycle", {31'b0, oDone}, 0);

    runSearch(4, 0, 0, 1'b0);
    expQ = '{7, 3, 5, 4};
    chkSeq("t4", expQ);
    chk("t4_done", {31'b0, gotDone}, 1);
    chk("t4_result", {28'b0, oResult}, 4);
    chk("t4_steps", {29'b0, oSteps}, 4);
    chk("t4_busy", {31'b0, oBusy}, 0);

    runSearch(0, 0, 0, 1'b0);
    expQ = '{7, 3, 1, 0};
    chkSeq("t0", expQ);
    chk("t0_result", {28'b0, oResult}, 0);
    chk("t0_steps", {29'b0, oSteps}, 4);

    runSearch(15, 0, 0, 1'b0);
    expQ = '{7, 11, 13, 14, 15};
    chkSeq("t15", expQ);
    chk("t15_done", {31'b0, gotDone}, 1);
    chk("t15_result", {28'b0, oResult}, 15);
    chk("t15_steps", {29'b0, oSteps}, 5);

    runSearch(0, 0, 1, 1'b0);
    expQ = '{7, 3, 1, 0};
    chkSeq("all_large", expQ);
    chk("all_large_err", {31'b0, gotError}, 1);
    chk("all_large_done", {31'b0, gotDone}, 0);
    chk("all_large_result", {28'b0, oResult}, 15);
    chk("all_large_steps", {29'b0, oSteps}, 4);
    @(negedge iClk);
    chk("err_one_cycle", {31'b0, oError}, 0);

    runSearch(0, 0, 2, 1'b0);
    chk("both_err", {31'b0, gotError}, 1);
    chk("both_busy", {31'b0, oBusy}, 0);
    chk("both_steps", {29'b0, oSteps}, 1);
    chk("both_result", {28'b0, oResult}, 15);

    runSearch(4, 5, 0, 1'b1);
    expQ = '{7, 3, 5, 4};
    chkSeq("t4_delay_midstart", expQ);
    chk("t4d_result", {28'b0, oResult}, 4);
    chk("t4d_steps", {29'b0, oSteps}, 4);

    for (int t = 0; t < 16; t++) begin
      runSearch(t, 5, 0, 1'b0);
      chk($sformatf("sweep%0d_done", t), {31'b0, gotDone}, 1);
      chk($sformatf("sweep%0d_result", t), {28'b0, oResult}, t);
      chk($sformatf("sweep%0d_steps_le5", t), {31'b0, (oSteps <= 3'd5)}, 1);
    end

    // reset mid-search after two accepts (target 9: 7 small, 11 large)
    @(negedge iClk) iStart = 1'b1;
    @(negedge iClk) iStart = 1'b0;
    @(negedge iClk) begin iRespValid = 1'b1; iSmall = 1'b1; end
    @(negedge iClk) begin iSmall = 1'b0; iLarge = 1'b1; end
    @(negedge iClk) begin iLarge = 1'b0; iRespValid = 1'b0; end
    chk("pre_rst_guess", {28'b0, oGuess}, 9);
    chk("pre_rst_steps", {29'b0, oSteps}, 2);
    iRst = 1'b1;
    iRespValid = 1'b1;
    @(negedge iClk) begin iRst = 1'b0; iRespValid = 1'b0; end
    chk("mid_rst_busy", {31'b0, oBusy}, 0);
    chk("mid_rst_valid", {31'b0, oGuessValid}, 0);
    chk("mid_rst_guess", {28'b0, oGuess}, 0);
    chk("mid_rst_result", {28'b0, oResult}, 0);
    chk("mid_rst_steps", {29'b0, oSteps}, 0);
    chk("mid_rst_done", {31'b0, oDone}, 0);
    chk("mid_rst_error", {31'b0, oError}, 0);

    runSearch(4, 0, 0, 1'b0);
    expQ = '{7, 3, 5, 4};
    chkSeq("post_rst", expQ);
    chk("post_rst_result", {28'b0, oResult}, 4);
    chk("post_rst_steps", {29'b0, oSteps}, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
